// File: rtl/huc_pkg.sv
// rtl/huc_pkg.sv - shared types and constants for the HuCard mapper memory channels
package huc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } fetch_state_e;

    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [1:0] BE_EVEN = 2'b01;
    localparam logic [1:0] BE_ODD  = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    // Sized for the widest mapper window; channels use the low bits they need.
    localparam int MEM_AW_MAX = 24;

    typedef struct packed {
        logic [MEM_AW_MAX-1:0] addr;
        logic                  we;
        logic [1:0]            be;
        logic [15:0]           wdat;
    } mem_req_t;

    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/huc_mem_fetch_if.sv
// rtl/huc_mem_fetch_if.sv - request/acknowledge bus to the 16-bit cart memory controller
interface huc_mem_fetch_if #(
    parameter int AW = 19
);
    logic          mem_req;
    logic [AW-2:0] mem_addr;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [15:0]   mem_wdat;
    logic          mem_ack;
    logic [15:0]   mem_rdat;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdat,
        input  mem_ack, mem_rdat
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdat,
        output mem_ack, mem_rdat
    );
endinterface

// File: rtl/huc_word_buf.sv
// rtl/huc_word_buf.sv - one-word tagged read buffer with lookup, fill, invalidate and clear
module huc_word_buf #(
    parameter int TW     = 18,
    parameter bit HIT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] lkp_tag,
    output logic          hit,
    output logic [15:0]   lkp_data,
    input  logic          fill_en,
    input  logic [TW-1:0] fill_tag,
    input  logic [15:0]   fill_data,
    input  logic          inval_en,
    input  logic          clr
);
    logic          valid_q, valid_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [15:0]   data_q, data_d;

    assign hit      = HIT_EN && valid_q && (tag_q == lkp_tag);
    assign lkp_data = data_q;

    // Invalidate only drops the entry when the looked-up word is the buffered one.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end else if (inval_en && hit) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/huc_mem_fetch.sv
// rtl/huc_mem_fetch.sv - mapper channel to cart memory fetch engine with one-word read buffer
module huc_mem_fetch
    import huc_pkg::*;
#(
    parameter int AW     = 19,
    parameter int TMO    = 64,
    parameter bit HIT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          ce,
    input  logic          ce2,
    input  logic          oe,
    input  logic          we,
    input  logic [7:0]    dati,
    output logic [7:0]    dato,
    output logic          busy,
    output logic          err,
    huc_mem_fetch_if.master mem
);
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    fetch_state_e  state_q, state_d;
    mem_req_t      req_q, req_d;
    logic          req_on_q, req_on_d;
    logic          a0_q, a0_d;
    logic [7:0]    dato_q, dato_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce2_q;

    logic          start;
    logic          buf_hit;
    logic [15:0]   buf_data;
    logic          fill_en, inval_en, buf_clr;
    logic          unused_addr_hi;

    assign start = ce2 & ~ce2_q & ce;

    huc_word_buf #(.TW(AW-1), .HIT_EN(HIT_EN)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .lkp_tag   (addr[AW-1:1]),
        .hit       (buf_hit),
        .lkp_data  (buf_data),
        .fill_en   (fill_en),
        .fill_tag  (req_q.addr[AW-2:0]),
        .fill_data (mem.mem_rdat),
        .inval_en  (inval_en),
        .clr       (buf_clr)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        req_on_d = req_on_q;
        a0_d     = a0_q;
        dato_d   = dato_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        fill_en  = 1'b0;
        inval_en = 1'b0;
        buf_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && oe && !we) begin
                    if (buf_hit) begin
                        dato_d = byte_sel(buf_data, addr[0]);
                    end else begin
                        req_d.addr = MEM_AW_MAX'(addr[AW-1:1]);
                        req_d.we   = 1'b0;
                        req_d.be   = BE_WORD;
                        req_on_d   = 1'b1;
                        a0_d       = addr[0];
                        cnt_d      = '0;
                        state_d    = RD;
                    end
                end else if (start && we && !oe) begin
                    req_d.addr = MEM_AW_MAX'(addr[AW-1:1]);
                    req_d.we   = 1'b1;
                    req_d.be   = addr[0] ? BE_ODD : BE_EVEN;
                    req_d.wdat = {dati, dati};
                    req_on_d   = 1'b1;
                    a0_d       = addr[0];
                    cnt_d      = '0;
                    inval_en   = 1'b1;
                    state_d    = WR;
                end
            end
            RD, WR: begin
                // An ack arriving on the last timeout cycle still completes normally.
                if (mem.mem_ack) begin
                    if (state_q == RD) begin
                        fill_en = 1'b1;
                        dato_d  = byte_sel(mem.mem_rdat, a0_q);
                    end
                    req_on_d = 1'b0;
                    req_d.we = 1'b0;
                    req_d.be = '0;
                    state_d  = IDLE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    if (state_q == RD) dato_d = BYTE_FF;
                    req_on_d = 1'b0;
                    req_d.we = 1'b0;
                    req_d.be = '0;
                    err_d    = 1'b1;
                    buf_clr  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            req_on_q <= 1'b0;
            a0_q     <= 1'b0;
            dato_q   <= BYTE_FF;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ce2_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            req_on_q <= req_on_d;
            a0_q     <= a0_d;
            dato_q   <= dato_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            ce2_q    <= ce2;
        end
    end

    assign unused_addr_hi = ^req_q.addr[MEM_AW_MAX-1:AW-1];

    assign dato          = dato_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;
    assign mem.mem_req   = req_on_q;
    assign mem.mem_addr  = req_q.addr[AW-2:0];
    assign mem.mem_we    = req_q.we;
    assign mem.mem_be    = req_q.be;
    assign mem.mem_wdat  = req_q.wdat;
endmodule
